// File: rtl/mash_nstage.sv
// MASH delta-sigma modulator for the fractional-N divider: run-time order 1..MAX_ORDER,
// HK-EFM modulus 2^WIDTH - HK_A, optional LFSR LSB dither, clock enable and coherent load.
module mash_nstage #(
  parameter int WIDTH     = 24,
  parameter int MAX_ORDER = 4,
  parameter int HK_A      = 1,
  parameter int OUT_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [2:0]       order_i,
  input  logic             dither_en_i,
  output logic [OUT_W-1:0] y_o,
  output logic             y_vld_o,
  output logic [WIDTH-1:0] e_o
);

  localparam int SW = WIDTH + 2;
  localparam logic [SW-1:0] MOD = {2'b01, {WIDTH{1'b0}}} - SW'(HK_A);

  logic [WIDTH-1:0]        acc     [MAX_ORDER];
  logic [WIDTH-1:0]        acc_nxt [MAX_ORDER];
  logic signed [OUT_W-1:0] dreg    [MAX_ORDER+1];
  logic signed [OUT_W-1:0] d       [MAX_ORDER];
  logic [WIDTH-1:0]        e_nxt;
  logic [WIDTH-1:0]        x_reg;
  logic [2:0]              order_reg;
  logic [2:0]              order_new;
  logic                    dither_reg;
  logic [15:0]             lfsr;

  // One EFM step: returns {carry, residue} with the residue reduced modulo MOD.
  function automatic logic [WIDTH:0] efm(input logic [WIDTH-1:0] a, input logic [SW-1:0] in);
    logic [SW-1:0] s;
    logic [SW-1:0] r;
    s = {2'b00, a} + in;
    r = (s >= MOD) ? s - MOD : s;
    return {s >= MOD, r[WIDTH-1:0]};
  endfunction

  function automatic logic signed [OUT_W-1:0] ext(input logic b);
    return $signed({{(OUT_W-1){1'b0}}, b});
  endfunction

  assign order_new = (order_i == 3'd0 || int'(order_i) > MAX_ORDER) ? 3'(MAX_ORDER) : order_i;

  // Stage 0: same-cycle accumulator cascade, then noise cancellation from the last stage down.
  always_comb begin : comb_stages
    logic [WIDTH-1:0]        prev;
    logic [SW-1:0]           stage_in;
    logic [WIDTH:0]          r;
    logic [MAX_ORDER-1:0]    cy;
    logic signed [OUT_W-1:0] d_up;
    logic signed [OUT_W-1:0] dk;
    prev     = x_reg;
    stage_in = '0;
    r        = '0;
    cy       = '0;
    d_up     = '0;
    dk       = '0;
    e_nxt    = '0;
    for (int k = 0; k < MAX_ORDER; k++) begin
      stage_in = {2'b00, prev};
      if (k == int'(order_reg) - 1 && dither_reg && lfsr[0])
        stage_in = stage_in + SW'(1);
      r = (k < int'(order_reg)) ? efm(acc[k], stage_in) : '0;
      cy[k]      = r[WIDTH];
      acc_nxt[k] = r[WIDTH-1:0];
      prev       = r[WIDTH-1:0];
      if (k == int'(order_reg) - 1)
        e_nxt = r[WIDTH-1:0];
    end
    for (int k = MAX_ORDER - 1; k >= 0; k--) begin
      if (k >= int'(order_reg))          dk = '0;
      else if (k == int'(order_reg) - 1) dk = ext(cy[k]);
      else                               dk = ext(cy[k]) + d_up - dreg[k+1];
      d[k] = dk;
      d_up = dk;
    end
  end

  // Stage 1: registered state and output; an order change on load clears the noise-shaping state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAX_ORDER; k++)  acc[k]  <= '0;
      for (int k = 0; k <= MAX_ORDER; k++) dreg[k] <= '0;
      y_o        <= '0;
      y_vld_o    <= 1'b0;
      e_o        <= '0;
      x_reg      <= '0;
      order_reg  <= 3'(MAX_ORDER);
      dither_reg <= 1'b0;
      lfsr       <= 16'hACE1;
    end else begin
      y_vld_o <= en_i;
      if (en_i) begin
        for (int k = 0; k < MAX_ORDER; k++) acc[k]  <= acc_nxt[k];
        for (int k = 1; k < MAX_ORDER; k++) dreg[k] <= d[k];
        y_o  <= d[0];
        e_o  <= e_nxt;
        lfsr <= {lfsr[5] ^ lfsr[3] ^ lfsr[2] ^ lfsr[0], lfsr[15:1]};
      end
      if (load_i) begin
        x_reg      <= x_i;
        order_reg  <= order_new;
        dither_reg <= dither_en_i;
        if (order_new != order_reg) begin
          for (int k = 0; k < MAX_ORDER; k++)  acc[k]  <= '0;
          for (int k = 0; k <= MAX_ORDER; k++) dreg[k] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mash_nstage.sv
// Bench for mash_nstage: an 8-bit plain-modulus instance checked cycle by cycle against a
// behavioural MASH model, plus a default-parameter instance for the HK-EFM small-input case.
module tb_mash_nstage;

  localparam int  W  = 8;
  localparam int  MO = 4;
  localparam longint MS = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         s_en = 0, s_load = 0, s_dith = 0;
  logic [W-1:0] s_x = '0;
  logic [2:0]   s_ord = '0;
  logic [4:0]   s_y;
  logic         s_vld;
  logic [W-1:0] s_e;

  logic         b_en = 0, b_load = 0, b_dith = 0;
  logic [23:0]  b_x = '0;
  logic [2:0]   b_ord = '0;
  logic [4:0]   b_y;
  logic         b_vld;
  logic [23:0]  b_e;

  mash_nstage #(.WIDTH(W), .MAX_ORDER(MO), .HK_A(0), .OUT_W(5)) dut (
    .clk(clk), .rst(rst), .en_i(s_en), .load_i(s_load), .x_i(s_x), .order_i(s_ord),
    .dither_en_i(s_dith), .y_o(s_y), .y_vld_o(s_vld), .e_o(s_e));

  mash_nstage big (
    .clk(clk), .rst(rst), .en_i(b_en), .load_i(b_load), .x_i(b_x), .order_i(b_ord),
    .dither_en_i(b_dith), .y_o(b_y), .y_vld_o(b_vld), .e_o(b_e));

  int checks = 0;
  int errors = 0;

  typedef struct { int y; longint e; } exp_t;
  exp_t sbq[$];

  longint      m_acc [MO];
  int          m_dreg [MO+2];
  logic [15:0] m_lfsr;
  longint      m_x;
  int          m_ord;
  bit          m_dith;
  int          m_ylast;
  bit          m_vld;

  int sum, mn, mx;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < MO; k++) m_acc[k] = 0;
    for (int k = 0; k < MO + 2; k++) m_dreg[k] = 0;
    m_lfsr = 16'hACE1; m_x = 0; m_ord = MO; m_dith = 0; m_ylast = 0; m_vld = 0;
  endfunction

  // Behavioural reference for one clock edge.
  function automatic void model_edge(input bit en, input bit ld, input int x, input int ord, input bit dith);
    longint nacc [MO];
    int     c [MO+1];
    int     dd [MO+2];
    longint in, s, prev;
    int     no;
    exp_t   ex;
    if (en) begin
      prev = m_x;
      for (int k = 0; k < MO; k++) begin
        nacc[k] = 0; c[k+1] = 0;
        if (k < m_ord) begin
          in = prev;
          if (k == m_ord - 1 && m_dith && m_lfsr[0]) in = in + 1;
          s = m_acc[k] + in;
          c[k+1]  = (s >= MS) ? 1 : 0;
          nacc[k] = (s >= MS) ? s - MS : s;
          prev    = nacc[k];
        end
      end
      for (int k = 0; k < MO + 2; k++) dd[k] = 0;
      dd[m_ord] = c[m_ord];
      for (int k = m_ord - 1; k >= 1; k--) dd[k] = c[k] + dd[k+1] - m_dreg[k+1];
      for (int k = 2; k <= MO; k++) m_dreg[k] = (k <= m_ord) ? dd[k] : 0;
      ex.y = dd[1]; ex.e = nacc[m_ord-1];
      sbq.push_back(ex);
      for (int k = 0; k < MO; k++) m_acc[k] = nacc[k];
      m_lfsr  = {^(m_lfsr & 16'h002D), m_lfsr[15:1]};
      m_ylast = dd[1];
    end
    m_vld = en;
    if (ld) begin
      no = (ord < 1 || ord > MO) ? MO : ord;
      if (no != m_ord) begin
        for (int k = 0; k < MO; k++) m_acc[k] = 0;
        for (int k = 0; k < MO + 2; k++) m_dreg[k] = 0;
      end
      m_x = x; m_ord = no; m_dith = dith;
    end
  endfunction

  task automatic check_out();
    exp_t ex;
    int   y;
    y = int'($signed(s_y));
    chk("y_vld", s_vld, m_vld);
    if (s_vld) begin
      if (sbq.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        ex = sbq.pop_front();
        chk("y", y, ex.y);
        chk("e", s_e, ex.e);
      end
      sum += y;
      if (y < mn) mn = y;
      if (y > mx) mx = y;
    end else begin
      chk("y_hold", y, m_ylast);
    end
  endtask

  task automatic cyc(input bit en, input bit ld, input int x, input int ord, input bit dith);
    s_en = en; s_load = ld; s_x = W'(x); s_ord = 3'(ord); s_dith = dith;
    model_edge(en, ld, x, ord, dith);
    @(posedge clk); #1;
    check_out();
    s_load = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_y", s_y, 0);
    chk("rst_e", s_e, 0);
    chk("rst_vld", s_vld, 0);
    #1 rst = 0;
    model_reset();
    sbq.delete();
  endtask

  typedef struct { int x; int ord; int n; int exp_sum; int lo; int hi; } row_t;
  row_t rows [4];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bsum, bnz, y;
    rows[0] = '{x: 0,   ord: 3, n: 100,  exp_sum: 0,   lo: 0,  hi: 0};
    rows[1] = '{x: 128, ord: 1, n: 256,  exp_sum: 128, lo: 0,  hi: 1};
    rows[2] = '{x: 64,  ord: 3, n: 1024, exp_sum: 256, lo: -3, hi: 4};
    rows[3] = '{x: 64,  ord: 4, n: 1024, exp_sum: 256, lo: -7, hi: 8};

    model_reset();
    #12 rst = 0;
    #1;
    chk("init_y", s_y, 0);
    chk("init_vld", s_vld, 0);

    for (int r = 0; r < 4; r++) begin
      do_reset();
      cyc(0, 1, rows[r].x, rows[r].ord, 0);
      sum = 0; mn = 1000; mx = -1000;
      for (int i = 0; i < rows[r].n; i++) cyc(1, 0, rows[r].x, rows[r].ord, 0);
      chk($sformatf("sum_row%0d", r), sum, rows[r].exp_sum);
      chk($sformatf("min_row%0d_ok", r), (mn >= rows[r].lo), 1);
      chk($sformatf("max_row%0d_ok", r), (mx <= rows[r].hi), 1);
    end

    // order 3 -> 2 with en low clears state; same-order load with en high keeps it
    do_reset();
    cyc(0, 1, 77, 3, 0);
    for (int i = 0; i < 37; i++) cyc(1, 0, 77, 3, 0);
    cyc(0, 1, 77, 2, 0);
    for (int i = 0; i < 50; i++) cyc(1, 0, 77, 2, 0);
    cyc(1, 1, 150, 2, 0);
    for (int i = 0; i < 30; i++) cyc(1, 0, 150, 2, 0);

    // enable pattern 1,0,0,1 holds outputs during the low cycles
    cyc(0, 1, 45, 3, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 45, 3, 0);
      cyc(0, 0, 45, 3, 0);
      cyc(0, 0, 45, 3, 0);
      cyc(1, 0, 45, 3, 0);
    end

    // async reset pulse in the middle of a run
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 4, 0);
    cyc(1, 1, 200, 4, 0);
    for (int i = 0; i < 40; i++) cyc(1, 0, 200, 4, 0);

    // dither on, then order clamping of out-of-range requests
    do_reset();
    cyc(0, 1, 64, 2, 1);
    for (int i = 0; i < 200; i++) cyc(1, 0, 64, 2, 1);
    cyc(0, 1, 255, 1, 1);
    for (int i = 0; i < 60; i++) cyc(1, 0, 255, 1, 1);
    cyc(0, 1, 30, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 30, 0, 0);
    cyc(1, 1, 90, 7, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 90, 7, 0);

    // default-parameter instance: HK-EFM, order 3, x = 1
    do_reset();
    chk("big_rst_y", b_y, 0);
    chk("big_rst_e", b_e, 0);
    b_load = 1; b_x = 24'd1; b_ord = 3'd3; b_en = 0;
    @(posedge clk); #1;
    b_load = 0; b_en = 1;
    bsum = 0; bnz = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      y = int'($signed(b_y));
      bsum += y;
      if (y != 0) bnz++;
      if (b_vld !== 1'b1) chk("big_vld", b_vld, 1);
    end
    b_en = 0;
    chk("big_nonzero", (bnz > 0), 1);
    chk("big_sum_ok", (bsum >= -4 && bsum <= 4), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mash_nstage.md
Name: mash_nstage

Overview:
- Parametrised MASH delta-sigma modulator for the fractional-N divider, the successor of the fixed 1-1-1 modulator.
- Run-time selectable order (1..MAX_ORDER cascaded EFM stages) with an optional HK-EFM modulus reduction.
- Adds an LFSR dither option, a clock enable, and a load strobe that applies a new fraction and order coherently.
- Output is a registered signed division-ratio offset to be added to the integer divide value.

Parameters:
- WIDTH, 24, accumulator/fraction width.
- MAX_ORDER, 4, number of instantiated stages (1..4).
- HK_A, 1, HK-EFM constant. Modulus M = 2^WIDTH - HK_A. HK_A = 0 gives a plain 2^WIDTH accumulator. Legal range 0..2^(WIDTH-1)-1.
- OUT_W, 5, signed output width. Must satisfy 2^(OUT_W-1) > 2^(MAX_ORDER-1).

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- en_i, in, 1, clock enable. When low, all state holds.
- load_i, in, 1, strobe: capture x_i, order_i and dither_en_i.
- x_i, in, WIDTH, fraction numerator. Legal range 0..M-1.
- order_i, in, 3, requested order. Values outside 1..MAX_ORDER are clamped to MAX_ORDER.
- dither_en_i, in, 1, enables LSB dither.
- y_o, out, OUT_W, signed quantiser output.
- y_vld_o, out, 1, high in the cycle after each enabled update.
- e_o, out, WIDTH, accumulator of the last active stage.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values: all accumulators, difference registers, y_o, y_vld_o and e_o are 0. x_reg = 0, order_reg = MAX_ORDER, dither_reg = 0, LFSR = 16'hACE1.
- Load: when load_i=1 (sampled regardless of en_i), x_reg, order_reg and dither_reg are updated at the clock edge.
  - If the new order differs from order_reg, all accumulators and difference registers clear to 0 on that edge. The LFSR does not clear.
  - The loaded values take effect from the next enabled cycle.
- Stage k (1..order_reg), per enabled cycle:
  - in_1 = x_reg; in_k = acc_{k-1} after its update (same-cycle cascade, combinational chain).
  - Last active stage: in_k gets +1 when dither_reg=1 and LFSR bit0=1.
  - s = acc_k + in_k, computed WIDTH+2 bits wide, unsigned.
  - If s >= M: c_k = 1 and acc_k <= s - M. Otherwise c_k = 0 and acc_k <= s.
- Inactive stages (k > order_reg): accumulator held at 0, c_k = 0.
- Noise cancellation, combinational within the update cycle:
  - d_N = c_N, where N = order_reg.
  - d_k = c_k + d_{k+1} - dreg_{k+1}.
  - dreg_{k+1} <= d_{k+1} each enabled cycle.
  - All arithmetic is signed, sign-extended to OUT_W.
- Output:
  - y_o <= d_1 registered, so latency is 1 clock from the enabled edge.
  - y_o range is -(2^(N-1)-1)..2^(N-1).
  - e_o <= acc_N.
- LFSR: Fibonacci x^16+x^14+x^13+x^11+1, shifts once per enabled cycle only.
- en_i=0: no state changes except load capture. y_o holds its last value; y_vld_o=0.
- Simultaneous load_i and en_i: the update uses the old registered values; the new values apply from the next enabled cycle.
- Reset mid-operation: immediate asynchronous clear to reset values. The first y_vld_o arrives 1 cycle after the first enabled edge following deassertion.
- Long-run mean: over any multiple of the sequence period, the mean of y_o equals x_reg/M exactly with dither off.

Test Plan:
- Reset, x_i=0, order 3, en=1 for 100 cycles -> y_o=0 every cycle, y_vld_o=1 from cycle 2.
- WIDTH=8, HK_A=0, order 1, x=128 -> y_o alternates 0,1 (first 1 on the 2nd enabled update). Sum over 256 cycles = 128.
- WIDTH=8, HK_A=0, order 3, x=64, 1024 cycles -> sum of y_o = 256, all samples within -3..4. Order 4 with the same input -> sum 256, range -7..8.
- Default WIDTH, HK_A=1, order 3, x=1 -> no lock-up to a constant, and y_o is not identically 0 within 2^25 cycles. Compare against the golden model: sum equals floor(n·x/M) ± 4.
- Mid-run load from order 3 to order 2 -> next cycle all accumulators read 0 and the output matches a fresh order-2 model. Loading the same order keeps the accumulators.
- en_i toggled 1,0,0,1 -> y_o and accumulators frozen during the low cycles, y_vld_o=0 then. Async rst pulse mid-sequence -> outputs are 0 within the same cycle.
